// File: rtl/axis_pulse_gen_pkg.sv
// Shared types and helpers for the synthetic pulse generator: FSM state encoding,
// decay-shift width and saturation limits for signed/unsigned sample words.
package axis_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int DECAY_SHIFT_W = 4;
  localparam int LIMIT_W       = 64;

  // Largest unsigned value representable in w bits (w <= LIMIT_W).
  function automatic logic [LIMIT_W-1:0] unsigned_max(input int w);
    logic [LIMIT_W-1:0] one;
    one = 1;
    return (one << w) - one;
  endfunction

  // Largest positive two's-complement value representable in w bits.
  function automatic logic [LIMIT_W-1:0] signed_max(input int w);
    logic [LIMIT_W-1:0] one;
    one = 1;
    return (one << (w - 1)) - one;
  endfunction

endpackage

// File: rtl/pulse_gen_sat_add.sv
// Saturating add of a base word (signed or unsigned) and an unsigned addend.
// The addend is never negative, so only the upper limit is ever clamped.
module pulse_gen_sat_add
  import axis_pulse_gen_pkg::*;
#(
  parameter int W         = 16,
  parameter bit IS_SIGNED = 1'b0
) (
  input  logic [W-1:0] base,
  input  logic [W-1:0] addend,
  output logic [W-1:0] sum
);

  generate
    if (IS_SIGNED) begin : g_signed
      // A full-range unsigned addend on a signed base needs one bit beyond W+1.
      localparam logic [W-1:0] LIMIT = W'(signed_max(W));
      logic signed [W+1:0] wide;
      assign wide = $signed({{2{base[W-1]}}, base}) + $signed({2'b00, addend});
      assign sum  = (wide > $signed({2'b00, LIMIT})) ? LIMIT : wide[W-1:0];
    end else begin : g_unsigned
      localparam logic [W-1:0] LIMIT = W'(unsigned_max(W));
      logic [W:0] wide;
      assign wide = {1'b0, base} + {1'b0, addend};
      assign sum  = wide[W] ? LIMIT : wide[W-1:0];
    end
  endgenerate

endmodule

// File: rtl/axis_pulse_height_generator.sv
// Synthetic detector-pulse source: baseline, linear rise, shift-based exponential decay, dead gap.
// Optional pile-up emulation (accepting amplitudes during decay) is enabled by `PULSE_GEN_PILEUP_EN.
module axis_pulse_height_generator
  import axis_pulse_gen_pkg::*;
#(
  parameter int    AXIS_TDATA_WIDTH  = 16,
  parameter string AXIS_TDATA_SIGNED = "FALSE",
  parameter int    CNTR_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] bln_data,
  input  logic [CNTR_WIDTH-1:0]       rise_step,
  input  logic [DECAY_SHIFT_W-1:0]    decay_shift,
  input  logic [CNTR_WIDTH-1:0]       gap_len,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid
);

  localparam int W         = AXIS_TDATA_WIDTH;
  localparam int SUM_W     = ((W > CNTR_WIDTH) ? W : CNTR_WIDTH) + 1;
  localparam bit IS_SIGNED = (AXIS_TDATA_SIGNED == "TRUE");

  state_t                state_reg, state_next;
  logic [W-1:0]          pulse_reg, pulse_next;
  logic [W-1:0]          amp_reg, amp_next;
  logic [CNTR_WIDTH-1:0] cnt_reg, cnt_next;
  logic [W-1:0]          tdata_reg;
  logic                  tvalid_reg;

  logic                  adv;
  logic                  accept;
  logic                  ready_in_state;
  logic [W-1:0]          step_val;
  logic [W-1:0]          out_sat;

  logic [CNTR_WIDTH-1:0] step_eff;
  logic [SUM_W-1:0]      rise_sum;
  logic [W-1:0]          rise_val;
  logic [W-1:0]          decay_dec;
  logic [W-1:0]          decay_amt;
  logic [W-1:0]          decay_val;
  logic [CNTR_WIDTH:0]   cnt_inc;

  assign adv    = tvalid_reg & m_axis_tready;
  assign accept = s_axis_tvalid & s_axis_tready;

`ifdef PULSE_GEN_PILEUP_EN
  logic [W-1:0] pile_amp;

  pulse_gen_sat_add #(
    .W         (W),
    .IS_SIGNED (1'b0)
  ) u_pile_sat (
    .base   (pulse_reg),
    .addend (s_axis_tdata),
    .sum    (pile_amp)
  );

  assign ready_in_state = (state_reg == IDLE) || (state_reg == DECAY);
`else
  assign ready_in_state = (state_reg == IDLE);
`endif

  // Amplitudes are only taken once the sample stream is running.
  assign s_axis_tready = ready_in_state & tvalid_reg;

  assign step_eff = (rise_step == '0) ? CNTR_WIDTH'(1) : rise_step;
  assign rise_sum = SUM_W'(pulse_reg) + SUM_W'(step_eff);
  assign rise_val = (rise_sum >= SUM_W'(amp_reg)) ? amp_reg : rise_sum[W-1:0];

  assign decay_dec = pulse_reg >> decay_shift;
  assign decay_amt = (decay_dec == '0) ? W'(1) : decay_dec;
  assign decay_val = (decay_amt >= pulse_reg) ? '0 : (pulse_reg - decay_amt);

  assign cnt_inc = {1'b0, cnt_reg} + {{CNTR_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_next = state_reg;
    amp_next   = amp_reg;
    cnt_next   = cnt_reg;
    step_val   = '0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          amp_next = s_axis_tdata;
          cnt_next = '0;
          if (s_axis_tdata != '0) begin
            state_next = RISE;
          end else if (gap_len != '0) begin
            state_next = GAP;
          end
        end
      end

      RISE: begin
        step_val = rise_val;
        if (adv && (rise_val == amp_reg)) begin
          state_next = DECAY;
        end
      end

      DECAY: begin
        step_val = decay_val;
        if (adv && (decay_val == '0)) begin
          cnt_next   = '0;
          state_next = (gap_len == '0) ? IDLE : GAP;
        end
`ifdef PULSE_GEN_PILEUP_EN
        // A piled-up amplitude stacks on the current pulse and overrides a decay-to-zero exit.
        if (accept) begin
          amp_next   = pile_amp;
          state_next = RISE;
        end
`endif
      end

      GAP: begin
        if (adv) begin
          cnt_next = cnt_inc[CNTR_WIDTH-1:0];
          if (cnt_inc >= {1'b0, gap_len}) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    pulse_next = adv ? step_val : pulse_reg;
  end

  pulse_gen_sat_add #(
    .W         (W),
    .IS_SIGNED (IS_SIGNED)
  ) u_out_sat (
    .base   (bln_data),
    .addend (step_val),
    .sum    (out_sat)
  );

  // The first cycle after reset loads baseline so the stream never shows a stale zero as valid.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg  <= IDLE;
      pulse_reg  <= '0;
      amp_reg    <= '0;
      cnt_reg    <= '0;
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pulse_reg  <= pulse_next;
      amp_reg    <= amp_next;
      cnt_reg    <= cnt_next;
      tvalid_reg <= 1'b1;
      if (adv || !tvalid_reg) begin
        tdata_reg <= out_sat;
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;

endmodule

// File: tb/tb_axis_pulse_height_generator.sv
// Directed bench for axis_pulse_height_generator: rise/decay/gap shapes, stalls, saturation,
// zero amplitude/step, pile-up behaviour (follows `PULSE_GEN_PILEUP_EN) and mid-pulse reset.
module tb_axis_pulse_height_generator;

`ifdef PULSE_GEN_PILEUP_EN
  localparam bit PILEUP = 1'b1;
`else
  localparam bit PILEUP = 1'b0;
`endif

  logic        aclk;
  logic        aresetn;
  logic [15:0] bln_data;
  logic [15:0] rise_step;
  logic [3:0]  decay_shift;
  logic [15:0] gap_len;
  logic        s_axis_tready;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;

  int vectors;
  int miscompares;

  axis_pulse_height_generator dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .bln_data      (bln_data),
    .rise_step     (rise_step),
    .decay_shift   (decay_shift),
    .gap_len       (gap_len),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle amplitude offer; output sample of that edge is returned in the caller's check.
  task automatic offer(input logic [15:0] amp);
    s_axis_tdata  = amp;
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (s_axis_tready && (m_axis_tdata == bln_data)) break;
      step();
    end
    chk(tag, {31'd0, s_axis_tready}, 32'd1);
  endtask

  int exp1 [16] = '{150, 200, 250, 300, 200, 150, 125, 113, 107, 104, 102, 101, 100, 100, 100, 100};
  int exp4 [6]  = '{101, 102, 103, 102, 101, 100};
  int exp5 [3];
  int idx;
  logic exp_rdy;

  initial begin
    vectors       = 0;
    miscompares   = 0;
    aresetn       = 1'b0;
    bln_data      = 16'd100;
    rise_step     = 16'd50;
    decay_shift   = 4'd1;
    gap_len       = 16'd3;
    s_axis_tdata  = 16'd0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tdata", {16'd0, m_axis_tdata}, 32'd0);
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    aresetn = 1'b1;
    step();
    chk("rel_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("rel_tdata", {16'd0, m_axis_tdata}, 32'd100);
    chk("rel_tready", {31'd0, s_axis_tready}, 32'd1);
    step();
    chk("idle_tdata", {16'd0, m_axis_tdata}, 32'd100);

    // Scenario 1: basic pulse shape
    offer(16'd200);
    chk("t1_accept_tdata", {16'd0, m_axis_tdata}, 32'd100);
    chk("t1_accept_tready", {31'd0, s_axis_tready}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("t1_seq%0d", k), {16'd0, m_axis_tdata}, exp1[k]);
      exp_rdy = (k == 15) || (PILEUP && (k >= 3) && (k <= 11));
      chk($sformatf("t1_rdy%0d", k), {31'd0, s_axis_tready}, {31'd0, exp_rdy});
    end

    // Scenario 2: same pulse with consumer stalling every other cycle
    offer(16'd200);
    chk("t2_accept_tdata", {16'd0, m_axis_tdata}, 32'd100);
    idx = 0;
    for (int i = 0; i < 64 && idx < 16; i++) begin
      m_axis_tready = (i % 2 == 1);
      step();
      if (m_axis_tready) idx++;
      chk($sformatf("t2_seq%0d", i), {16'd0, m_axis_tdata}, (idx == 0) ? 32'd100 : exp1[idx-1]);
    end
    chk("t2_count", idx, 32'd16);
    m_axis_tready = 1'b1;
    wait_idle("t2_idle");

    // Scenario 3: saturation at all-ones
    bln_data  = 16'd65000;
    rise_step = 16'd1000;
    offer(16'd1000);
    chk("t3_accept_tdata", {16'd0, m_axis_tdata}, 32'd65000);
    step();
    chk("t3_peak_sat", {16'd0, m_axis_tdata}, 32'd65535);
    step();
    chk("t3_decay1", {16'd0, m_axis_tdata}, 32'd65500);
    step();
    chk("t3_decay2", {16'd0, m_axis_tdata}, 32'd65250);
    wait_idle("t3_idle");
    bln_data  = 16'd100;
    rise_step = 16'd50;
    step();
    chk("t3_bln_back", {16'd0, m_axis_tdata}, 32'd100);

    // Scenario 4a: zero amplitude goes straight to the gap
    offer(16'd0);
    chk("t4a_accept_tready", {31'd0, s_axis_tready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t4a_gap%0d", k), {16'd0, m_axis_tdata}, 32'd100);
      chk($sformatf("t4a_rdy%0d", k), {31'd0, s_axis_tready}, (k == 2) ? 32'd1 : 32'd0);
    end

    // Scenario 4b: rise_step=0 counts by one, gap_len=0 returns straight to idle
    rise_step = 16'd0;
    gap_len   = 16'd0;
    offer(16'd3);
    chk("t4b_accept_tdata", {16'd0, m_axis_tdata}, 32'd100);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("t4b_seq%0d", k), {16'd0, m_axis_tdata}, exp4[k]);
      exp_rdy = (k == 5) || (PILEUP && (k >= 2) && (k <= 4));
      chk($sformatf("t4b_rdy%0d", k), {31'd0, s_axis_tready}, {31'd0, exp_rdy});
    end

    // Scenario 4c: decay_shift=0 collapses the pulse in one sample
    decay_shift = 4'd0;
    rise_step   = 16'd100;
    offer(16'd50);
    step();
    chk("t4c_peak", {16'd0, m_axis_tdata}, 32'd150);
    chk("t4c_rdy_decay", {31'd0, s_axis_tready}, {31'd0, PILEUP});
    step();
    chk("t4c_zero", {16'd0, m_axis_tdata}, 32'd100);
    chk("t4c_rdy_idle", {31'd0, s_axis_tready}, 32'd1);

    // Scenario 5: amplitude offered mid-decay at pulse=100
    decay_shift = 4'd1;
    rise_step   = 16'd50;
    gap_len     = 16'd3;
    offer(16'd200);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t5_pre%0d", k), {16'd0, m_axis_tdata}, exp1[k]);
    end
    chk("t5_rdy_decay", {31'd0, s_axis_tready}, {31'd0, PILEUP});
    if (PILEUP) exp5 = '{150, 200, 250};
    else        exp5 = '{150, 125, 113};
    offer(16'd200);
    chk("t5_post0", {16'd0, m_axis_tdata}, exp5[0]);
    for (int k = 1; k < 3; k++) begin
      step();
      chk($sformatf("t5_post%0d", k), {16'd0, m_axis_tdata}, exp5[k]);
    end
    wait_idle("t5_idle");

    // Scenario 6: reset during the rise aborts the pulse
    offer(16'd200);
    step();
    chk("t6_rise", {16'd0, m_axis_tdata}, 32'd150);
    aresetn = 1'b0;
    step();
    chk("t6_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t6_rst_tdata", {16'd0, m_axis_tdata}, 32'd0);
    chk("t6_rst_tready", {31'd0, s_axis_tready}, 32'd0);
    aresetn = 1'b1;
    step();
    chk("t6_rel_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("t6_rel_tdata", {16'd0, m_axis_tdata}, 32'd100);
    chk("t6_rel_tready", {31'd0, s_axis_tready}, 32'd1);
    step();
    chk("t6_idle_tdata", {16'd0, m_axis_tdata}, 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
